serial_subtractor: RTL and testbench

- Bit-serial N-bit subtractor computing a - b - bin, LSB first, one bit per clock.
- Built from the full-subtractor difference/borrow equations, with a registered borrow carried between bits.
- Serves as the subtract-side counterpart to the team's full-adder arithmetic blocks.
- Used where area matters more than latency; a start/busy/done handshake sequences one operation at a time.

---
 rtl/serial_subtractor.sv | 117 +++++++++++
 tb/tb_serial_subtractor.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - bin, LSB first, one bit per clock, start/busy/done handshake.
// Optional SERIAL_SUBTRACTOR_SIGNED_OVF_EN adds a two's-complement overflow output.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, a, b, bin  request and operands, captured on the accepting IDLE edge
//   busy              high for exactly WIDTH cycles while bits are processed
//   done              one-cycle pulse when diff/bout (and ovf) become valid
//   diff, bout        difference modulo 2^WIDTH and borrow out of the MSB
//   ovf               signed overflow of the result (only with the macro)
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;

  logic x_d;
  logic y_d;
  logic bit_d;
  logic br_d;

  // Full-subtractor on the current LSBs and the running borrow.
  always_comb begin
    x_d   = sa_q[0];
    y_d   = sb_q[0];
    bit_d = x_d ^ y_d ^ br_q;
    br_d  = (~x_d & y_d) | (~(x_d ^ y_d) & br_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      br_q    <= 1'b0;
      cnt_q   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      diff    <= '0;
      bout    <= 1'b0;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sa_q    <= a;
            sb_q    <= b;
            br_q    <= bin;
            cnt_q   <= '0;
            busy    <= 1'b1;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          // diff doubles as the result shift register; it settles at done.
          diff  <= {bit_d, diff[WIDTH-1:1]};
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          br_q  <= br_d;
          if (cnt_q == LAST) begin
            busy    <= 1'b0;
            done    <= 1'b1;
            bout    <= br_d;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
            // Borrow into the MSB versus borrow out of it.
            ovf     <= br_q ^ br_d;
`endif
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        DONE: begin
          done    <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          done    <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed cases plus random
// operations against an integer-arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         bout;
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
  logic         ovf;
`endif

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp)
    else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  task automatic ref_sub(input logic [W-1:0] ta, input logic [W-1:0] tb,
                         input logic tbin, output logic [W-1:0] rd,
                         output logic rb, output logic ro);
    int ua;
    int ub;
    int ur;
    int sa;
    int sb;
    int sr;
    ua = int'(ta);
    ub = int'(tb);
    ur = ua - ub - int'(tbin);
    rb = (ur < 0);
    rd = W'(ur);
    sa = ta[W-1] ? ua - (1 << W) : ua;
    sb = tb[W-1] ? ub - (1 << W) : ub;
    sr = sa - sb - int'(tbin);
    ro = (sr < -(1 << (W - 1))) || (sr > (1 << (W - 1)) - 1);
  endtask

  task automatic do_op(input string tag, input logic [W-1:0] ta,
                       input logic [W-1:0] tb, input logic tbin);
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           lat;
    int           bcy;
    ref_sub(ta, tb, tbin, ed, eb, eo);
    @(negedge clk);
    a = ta;
    b = tb;
    bin = tbin;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = ~ta;
    b = ~tb;
    lat = 0;
    bcy = 0;
    while (!done && lat < W + 4) begin
      if (busy) bcy++;
      @(posedge clk);
      #1;
      lat++;
    end
    chk({tag, ".lat"}, lat, W);
    chk({tag, ".busycyc"}, bcy, W);
    chk({tag, ".busy"}, busy, 1'b0);
    chk({tag, ".diff"}, diff, ed);
    chk({tag, ".bout"}, bout, eb);
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    chk({tag, ".ovf"}, ovf, eo);
`endif
    @(posedge clk);
    #1;
    chk({tag, ".donepulse"}, done, 1'b0);
    chk({tag, ".hold"}, diff, ed);
  endtask

  initial begin
    logic [W-1:0] ed;
    logic         eb;
    logic         eo;
    int           t1;
    int           t2;
    int           lat;
    int           ndone;

    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.diff", diff, '0);
    chk("rst.bout", bout, 1'b0);
`ifdef SERIAL_SUBTRACTOR_SIGNED_OVF_EN
    chk("rst.ovf", ovf, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;

    do_op("basic", 8'd100, 8'd37, 1'b0);
    do_op("under", 8'h00, 8'h01, 1'b0);
    do_op("bin1", 8'h05, 8'h05, 1'b1);
    do_op("bin2", 8'hFF, 8'h00, 1'b1);
    do_op("sovf1", 8'h80, 8'h01, 1'b0);
    do_op("sovf2", 8'h7F, 8'hFF, 1'b0);

    // start held high across an operation; operands change mid-SHIFT.
    @(negedge clk);
    a = 8'h10;
    b = 8'h01;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    a = 8'h33;
    b = 8'h11;
    lat = 0;
    while (!done && lat < W + 4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    t1 = cyc;
    chk("hs.first", diff, 8'h0F);
    lat = 0;
    @(posedge clk);
    #1;
    while (!done && lat < 2 * W + 4) begin
      @(posedge clk);
      #1;
      lat++;
    end
    t2 = cyc;
    start = 1'b0;
    // DONE cycle, one IDLE cycle that accepts, then WIDTH shift cycles.
    chk("hs.interval", t2 - t1, W + 2);
    chk("hs.second", diff, 8'h22);

    // Reset during bit 4 discards the operation.
    @(negedge clk);
    a = 8'hAA;
    b = 8'h55;
    bin = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid.busy", busy, 1'b0);
    chk("mid.diff", diff, '0);
    chk("mid.bout", bout, 1'b0);
    ndone = 0;
    repeat (W + 2) begin
      @(posedge clk);
      #1;
      if (done) ndone++;
    end
    chk("mid.nodone", ndone, 0);
    do_op("after", 8'h09, 8'h03, 1'b0);

    for (int i = 0; i < 30; i++) begin
      do_op("rand", W'($urandom), W'($urandom), 1'($urandom));
    end

    ref_sub(8'h7F, 8'h80, 1'b1, ed, eb, eo);
    do_op("edge", 8'h7F, 8'h80, 1'b1);
    chk("edge.model", {eo, eb, ed}, {1'b1, 1'b1, 8'hFE});

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
